// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage SRAM access path.
// Used by the SRAM controller and the reusable phase counter.
package mem_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

endpackage

// File: rtl/phase_counter.sv
// Wait-state counter: counts 0..LIMIT-1 while enabled, wraps to 0 after the
// terminal count, and flags the terminal cycle combinationally.
module phase_counter #(
  parameter int LIMIT = 3,
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          terminal
);

  assign terminal = (count == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_sram_controller.sv
// Splits one 32-bit MEM-stage load/store into two 16-bit SRAM phases with
// programmable wait states; ready low freezes the pipeline meanwhile.
module mem_sram_controller
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
  parameter int          ACCESS_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  state_t      state_reg, state_next;
  logic        op_write_reg;
  logic [16:0] word_addr_reg;
  logic [31:0] data_reg;
  logic        request;
  logic        phase_active;
  logic        phase_last;
  logic [CW-1:0] phase_count;
  logic [18:0] eff_low;
  logic        unused_bits;

  // Only eff[18:2] reaches the SRAM, and the low bits of a modular
  // subtraction depend only on the low bits of its operands.
  assign eff_low     = address[18:0] - BASE_ADDR[18:0];
  assign unused_bits = ^{address[31:19], eff_low[1:0], phase_count};

  assign request      = rd_en | wr_en;
  assign phase_active = (state_reg == LOW) || (state_reg == HIGH);

  phase_counter #(
    .LIMIT(ACCESS_CYCLES)
  ) u_phase_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_reg == IDLE),
    .en      (phase_active),
    .count   (phase_count),
    .terminal(phase_last)
  );

  always_comb begin
    state_next  = state_reg;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = ~request;
        if (request) state_next = LOW;
      end
      LOW: begin
        sram_addr = {word_addr_reg, 1'b0};
        if (op_write_reg) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = data_reg[15:0];
        end
        if (phase_last) state_next = HIGH;
      end
      HIGH: begin
        sram_addr = {word_addr_reg, 1'b1};
        if (op_write_reg) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = data_reg[31:16];
        end
        if (phase_last) state_next = DONE;
      end
      DONE: begin
        // The pipeline consumes the request this cycle, so inputs are ignored.
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      op_write_reg  <= 1'b0;
      word_addr_reg <= '0;
      data_reg      <= '0;
      read_data     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && request) begin
        op_write_reg  <= wr_en;
        word_addr_reg <= eff_low[18:2];
        data_reg      <= write_data;
      end
      if (!op_write_reg && phase_last) begin
        if (state_reg == LOW)  read_data[15:0]  <= sram_dq_in;
        if (state_reg == HIGH) read_data[31:16] <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_sram_controller.sv
// Directed bench for the SRAM controller: default-timing instance (a) plus a
// single-cycle-phase instance (b), each against a small SRAM model.
module tb_mem_sram_controller;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, preload;
  logic        wr_en, rd_en, wr_en_b, rd_en_b;
  logic [31:0] address, write_data, address_b, write_data_b;
  logic [31:0] read_data, read_data_b;
  logic        ready, ready_b, sram_we_n, sram_we_n_b, sram_dq_oe, sram_dq_oe_b;
  logic [17:0] sram_addr, sram_addr_b;
  logic [15:0] sram_dq_out, sram_dq_out_b, sram_dq_in, sram_dq_in_b;

  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  int run_a, run_b;
  logic [17:0] last_a, last_b;

  int checks = 0;
  int passed = 0;

  mem_sram_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(3)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
  );

  mem_sram_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .rd_en(rd_en_b), .address(address_b),
    .write_data(write_data_b), .read_data(read_data_b), .ready(ready_b),
    .sram_addr(sram_addr_b), .sram_we_n(sram_we_n_b), .sram_dq_out(sram_dq_out_b),
    .sram_dq_oe(sram_dq_oe_b), .sram_dq_in(sram_dq_in_b)
  );

  assign sram_dq_in   = mem_a[sram_addr[7:0]];
  assign sram_dq_in_b = mem_b[sram_addr_b[7:0]];

  // SRAM models: a write commits only after the strobe has been held low at
  // one address for a full phase, so a truncated phase leaves memory intact.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem_a[i] = 16'h0000;
      mem_a[4] = 16'h5678; mem_a[5] = 16'h1234;
      mem_a[6] = 16'hAAAA; mem_a[7] = 16'hBBBB;
      mem_a[11] = 16'h7777;
      run_a = 0;
    end else if (!sram_we_n) begin
      if (run_a != 0 && sram_addr == last_a) run_a = run_a + 1;
      else run_a = 1;
      last_a = sram_addr;
      if (run_a == 3) mem_a[sram_addr[7:0]] = sram_dq_out;
    end else begin
      run_a = 0;
    end
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem_b[i] = 16'h0000;
      mem_b[0] = 16'h4321; mem_b[1] = 16'h8765;
      run_b = 0;
    end else if (!sram_we_n_b) begin
      if (run_b != 0 && sram_addr_b == last_b) run_b = run_b + 1;
      else run_b = 1;
      last_b = sram_addr_b;
      if (run_b == 1) mem_b[sram_addr_b[7:0]] = sram_dq_out_b;
    end else begin
      run_b = 0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; preload = 1'b1;
    next_cycle();
    next_cycle();
    preload = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else passed++;
    checks++; if (sram_we_n !== 1'b1) $display("FAIL reset_we_n: got %b expected 1", sram_we_n); else passed++;
    checks++; if (sram_dq_oe !== 1'b0) $display("FAIL reset_oe: got %b expected 0", sram_dq_oe); else passed++;
    checks++; if (sram_addr !== 18'd0) $display("FAIL reset_addr: got %h expected 0", sram_addr); else passed++;
    checks++; if (sram_dq_out !== 16'h0) $display("FAIL reset_dq_out: got %h expected 0", sram_dq_out); else passed++;
    checks++; if (read_data !== 32'h0) $display("FAIL reset_read_data: got %h expected 0", read_data); else passed++;
    checks++; if (read_data_b !== 32'h0) $display("FAIL reset_read_data_b: got %h expected 0", read_data_b); else passed++;
    rst = 1'b0;
    next_cycle();
    $display("reset done");
  endtask

  task automatic test_write();
    logic        exp_ready, exp_we_n;
    logic [17:0] exp_addr;
    logic [15:0] exp_dq;
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1028; write_data = 32'hDEADBEEF;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_ready = (c == 7);
      exp_we_n  = !(c >= 1 && c <= 6);
      exp_addr  = (c >= 1 && c <= 3) ? 18'd2 : (c >= 4 && c <= 6) ? 18'd3 : 18'd0;
      exp_dq    = (c >= 1 && c <= 3) ? 16'hBEEF : (c >= 4 && c <= 6) ? 16'hDEAD : 16'h0;
      checks++; if (ready !== exp_ready) $display("FAIL write_ready c%0d: got %b expected %b", c, ready, exp_ready); else passed++;
      checks++; if (sram_we_n !== exp_we_n) $display("FAIL write_we_n c%0d: got %b expected %b", c, sram_we_n, exp_we_n); else passed++;
      checks++; if (sram_addr !== exp_addr) $display("FAIL write_addr c%0d: got %h expected %h", c, sram_addr, exp_addr); else passed++;
      checks++; if (sram_dq_out !== exp_dq) $display("FAIL write_dq_out c%0d: got %h expected %h", c, sram_dq_out, exp_dq); else passed++;
      checks++; if (sram_dq_oe !== !exp_we_n) $display("FAIL write_oe c%0d: got %b expected %b", c, sram_dq_oe, !exp_we_n); else passed++;
      if (c == 7) wr_en = 1'b0;
      next_cycle();
    end
    #1;
    checks++; if (mem_a[2] !== 16'hBEEF) $display("FAIL write_mem_lo: got %h expected beef", mem_a[2]); else passed++;
    checks++; if (mem_a[3] !== 16'hDEAD) $display("FAIL write_mem_hi: got %h expected dead", mem_a[3]); else passed++;
    $display("write addr=%0d data=%h", 1028, 32'hDEADBEEF);
  endtask

  task automatic test_read();
    rd_en = 1'b1; wr_en = 1'b0; address = 32'd1028;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (ready !== 1'(c == 7)) $display("FAIL read_ready c%0d: got %b expected %b", c, ready, (c == 7)); else passed++;
      checks++; if (sram_we_n !== 1'b1) $display("FAIL read_we_n c%0d: got %b expected 1", c, sram_we_n); else passed++;
      checks++; if (sram_dq_oe !== 1'b0) $display("FAIL read_oe c%0d: got %b expected 0", c, sram_dq_oe); else passed++;
      if (c == 4) begin
        checks++; if (read_data !== 32'h0000BEEF) $display("FAIL read_low_half: got %h expected 0000beef", read_data); else passed++;
      end
      if (c == 7) begin
        checks++; if (read_data !== 32'hDEADBEEF) $display("FAIL read_data: got %h expected deadbeef", read_data); else passed++;
        rd_en = 1'b0;
      end
      next_cycle();
    end
    $display("read addr=%0d data=%h", 1028, read_data);
  endtask

  task automatic test_back_to_back();
    rd_en = 1'b1; wr_en = 1'b0; address = 32'd1032;
    for (int c = 0; c < 16; c++) begin
      #1;
      checks++; if (ready !== 1'(c == 7 || c == 15)) $display("FAIL b2b_ready c%0d: got %b expected %b", c, ready, (c == 7 || c == 15)); else passed++;
      if (c == 7) begin
        checks++; if (read_data !== 32'h12345678) $display("FAIL b2b_first: got %h expected 12345678", read_data); else passed++;
        address = 32'd1036;
      end
      if (c == 9) begin
        checks++; if (sram_addr !== 18'd6) $display("FAIL b2b_second_addr: got %h expected 6", sram_addr); else passed++;
      end
      if (c == 15) begin
        checks++; if (read_data !== 32'hBBBBAAAA) $display("FAIL b2b_second: got %h expected bbbbaaaa", read_data); else passed++;
        rd_en = 1'b0;
      end
      next_cycle();
    end
    $display("back_to_back reads data=%h", read_data);
  endtask

  task automatic test_both_enables();
    rd_en = 1'b1; wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c == 1) begin
        checks++; if (sram_we_n !== 1'b0) $display("FAIL both_we_n: got %b expected 0", sram_we_n); else passed++;
        checks++; if (sram_dq_oe !== 1'b1) $display("FAIL both_oe: got %b expected 1", sram_dq_oe); else passed++;
      end
      if (c == 7) begin
        checks++; if (ready !== 1'b1) $display("FAIL both_ready: got %b expected 1", ready); else passed++;
        checks++; if (read_data !== 32'hBBBBAAAA) $display("FAIL both_read_data: got %h expected bbbbaaaa", read_data); else passed++;
        rd_en = 1'b0; wr_en = 1'b0;
      end
      next_cycle();
    end
    #1;
    checks++; if (mem_a[8] !== 16'hF00D) $display("FAIL both_mem_lo: got %h expected f00d", mem_a[8]); else passed++;
    checks++; if (mem_a[9] !== 16'hCAFE) $display("FAIL both_mem_hi: got %h expected cafe", mem_a[9]); else passed++;
    $display("write (rd+wr) addr=%0d data=%h", 1040, 32'hCAFEF00D);
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1044; write_data = 32'h99998888;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c == 4) begin
        checks++; if (sram_addr !== 18'd11) $display("FAIL rstmid_high_addr: got %h expected b", sram_addr); else passed++;
        rst = 1'b1; wr_en = 1'b0;
      end
      next_cycle();
    end
    #1;
    checks++; if (sram_we_n !== 1'b1) $display("FAIL rstmid_we_n: got %b expected 1", sram_we_n); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL rstmid_ready: got %b expected 1", ready); else passed++;
    checks++; if (read_data !== 32'h0) $display("FAIL rstmid_read_data: got %h expected 0", read_data); else passed++;
    checks++; if (sram_addr !== 18'd0) $display("FAIL rstmid_addr: got %h expected 0", sram_addr); else passed++;
    rst = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    checks++; if (sram_we_n !== 1'b1) $display("FAIL rstmid_idle_we_n: got %b expected 1", sram_we_n); else passed++;
    checks++; if (mem_a[10] !== 16'h8888) $display("FAIL rstmid_mem_lo: got %h expected 8888", mem_a[10]); else passed++;
    checks++; if (mem_a[11] !== 16'h7777) $display("FAIL rstmid_mem_hi: got %h expected 7777", mem_a[11]); else passed++;
    $display("write aborted by reset addr=%0d", 1044);
  endtask

  task automatic test_single_cycle_phase();
    rd_en_b = 1'b1; wr_en_b = 1'b0; address_b = 32'd1024;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (ready_b !== 1'(c == 3)) $display("FAIL fast_ready c%0d: got %b expected %b", c, ready_b, (c == 3)); else passed++;
      if (c == 1) begin
        checks++; if (sram_addr_b !== 18'd0) $display("FAIL fast_addr_lo: got %h expected 0", sram_addr_b); else passed++;
      end
      if (c == 2) begin
        checks++; if (sram_addr_b !== 18'd1) $display("FAIL fast_addr_hi: got %h expected 1", sram_addr_b); else passed++;
      end
      if (c == 3) begin
        checks++; if (read_data_b !== 32'h87654321) $display("FAIL fast_read_data: got %h expected 87654321", read_data_b); else passed++;
        rd_en_b = 1'b0;
      end
      next_cycle();
    end
    $display("read (1-cycle phase) addr=%0d data=%h", 1024, read_data_b);
  endtask

  initial begin
    rst = 1'b1; preload = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    wr_en_b = 1'b0; rd_en_b = 1'b0; address_b = '0; write_data_b = '0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_both_enables();
    test_reset_mid();
    test_single_cycle_phase();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
